// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and DMEM geometry for the port-B arbiter
package dmem_arb_pkg;
  localparam int DMEM_AW = 11;
  localparam int DMEM_DW = 16;
  typedef enum logic [1:0] {ARB_IDLE, ARB_CCD, ARB_ACC} arb_state_t;
  typedef enum logic {OWN_CCD, OWN_ACC} owner_t;
endpackage

// File: rtl/dmem_rd_return.sv
// dmem_rd_return: RD_LAT-deep read-valid pipe and accelerator read-data capture
module dmem_rd_return
  import dmem_arb_pkg::*;
#(
  parameter int DW     = DMEM_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_issue,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);
  logic [RD_LAT-1:0] vld;
  logic [DW-1:0]     rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      rdata_q <= '0;
    end else begin
      vld <= (vld << 1) | RD_LAT'(rd_issue);
      if (vld[RD_LAT-1]) rdata_q <= ram_q;
    end
  end
  assign rvalid = vld[RD_LAT-1];
  // q_b is live in the tail cycle; the register keeps it afterwards
  assign rdata  = rvalid ? ram_q : rdata_q;
endmodule

// File: rtl/dmem_portb_arbiter.sv
// dmem_portb_arbiter: round-robin, burst-bounded CCD/accelerator arbiter for DMEM port B
// Optional transfer/contention counters: define DMEM_PORTB_ARB_STATS_EN
module dmem_portb_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          ccd_req,
  input  logic          ccd_wren,
  input  logic [AW-1:0] ccd_addr,
  input  logic [DW-1:0] ccd_data,
  output logic          ccd_gnt,
  input  logic          acc_req,
  input  logic          acc_rden,
  input  logic          acc_wren,
  input  logic [AW-1:0] acc_addr,
  input  logic [DW-1:0] acc_wdata,
  output logic          acc_gnt,
  output logic [DW-1:0] acc_rdata,
  output logic          acc_rvalid,
  output logic [AW-1:0] ram_address_b,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_rden_b,
  output logic          ram_wren_b,
  input  logic [DW-1:0] ram_q_b
`ifdef DMEM_PORTB_ARB_STATS_EN
  ,
  output logic [15:0]   ccd_xfer_cnt,
  output logic [15:0]   acc_xfer_cnt,
  output logic [15:0]   contend_cnt
`endif
);
  arb_state_t state, state_nx;
  owner_t     last_owner;
  logic [7:0] burst_cnt;
  logic       at_limit;
  assign at_limit = burst_cnt == 8'(MAX_BURST - 1);
  always_comb begin
    state_nx = ARB_IDLE;
    case (state)
      ARB_IDLE: state_nx = ccd_req && acc_req ? (last_owner == OWN_ACC ? ARB_CCD : ARB_ACC) :
                           ccd_req ? ARB_CCD : acc_req ? ARB_ACC : ARB_IDLE;
      ARB_CCD:  state_nx = !ccd_req ? (acc_req ? ARB_ACC : ARB_IDLE) :
                           acc_req && at_limit ? ARB_ACC : ARB_CCD;
      ARB_ACC:  state_nx = !acc_req ? (ccd_req ? ARB_CCD : ARB_IDLE) :
                           ccd_req && at_limit ? ARB_CCD : ARB_ACC;
      default:  state_nx = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      burst_cnt  <= '0;
      last_owner <= OWN_ACC;
    end else begin
      state     <= state_nx;
      burst_cnt <= state_nx != state ? '0 :
                   state != ARB_IDLE && !at_limit ? burst_cnt + 8'd1 : burst_cnt;
      if (state_nx != state && state_nx != ARB_IDLE)
        last_owner <= state_nx == ARB_CCD ? OWN_CCD : OWN_ACC;
    end
  end
  logic rd_issue;
  assign ccd_gnt       = state == ARB_CCD;
  assign acc_gnt       = state == ARB_ACC;
  assign ram_address_b = ccd_gnt ? ccd_addr : acc_gnt ? acc_addr : '0;
  assign ram_data_b    = ccd_gnt ? ccd_data : acc_gnt ? acc_wdata : '0;
  assign ram_wren_b    = ((ccd_gnt & ccd_wren) | (acc_gnt & acc_wren)) & ~halt;
  // a simultaneous write takes the cycle, so no read is issued with it
  assign rd_issue      = acc_gnt & acc_rden & ~acc_wren;
  assign ram_rden_b    = rd_issue;
  dmem_rd_return #(.DW(DW), .RD_LAT(RD_LAT)) u_rd_return (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_issue (rd_issue),
    .ram_q    (ram_q_b),
    .rdata    (acc_rdata),
    .rvalid   (acc_rvalid)
  );
`ifdef DMEM_PORTB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccd_xfer_cnt <= '0;
      acc_xfer_cnt <= '0;
      contend_cnt  <= '0;
    end else begin
      if (ccd_gnt && ccd_wren) ccd_xfer_cnt <= ccd_xfer_cnt + 16'd1;
      if (acc_gnt && (acc_wren || acc_rden)) acc_xfer_cnt <= acc_xfer_cnt + 16'd1;
      if ((ccd_req && !ccd_gnt) || (acc_req && !acc_gnt)) contend_cnt <= contend_cnt + 16'd1;
    end
  end
`endif
endmodule
